// File: rtl/y_signature_misr.sv
// ---------------------------------------------------------------------------
// y_signature_misr
//
// Compresses the output bus of a DUT under equivalence test into a MISR
// signature. A run is requested with start and a sample count; the block then
// absorbs one y word per clock, without stalling, and pulses done once the
// requested number of samples has been absorbed.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, only honoured in IDLE
//   cycles     in   16  samples in the run, latched when start is accepted
//   y          in   Y_W DUT output bus being signed
//   busy       out  high while a run is absorbing samples
//   done       out  one-cycle pulse after the last sample (or a 0-length run)
//   signature  out  SIG_W current / final MISR value
//   sample_cnt out  16  samples absorbed in the current or last run
// ---------------------------------------------------------------------------
module y_signature_misr #(
    parameter int               Y_W   = 246,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      cycles,
    input  logic [Y_W-1:0]   y,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      sample_cnt
);

    // y is zero-extended up to a whole number of signature-wide words.
    localparam int NWORDS = (Y_W + SIG_W - 1) / SIG_W;
    localparam int EXT_W  = NWORDS * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      cycles_lat;
    logic [15:0]      cnt_inc;
    logic [EXT_W-1:0] y_ext;
    logic [SIG_W-1:0] fold;

    // One MISR shift: Galois-style feedback of the outgoing MSB, then the
    // folded input word is mixed in.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] word);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ word;
    endfunction

    assign cnt_inc = sample_cnt + 16'd1;

    always_comb begin
        y_ext          = '0;
        y_ext[Y_W-1:0] = y;
        fold           = '0;
        for (int i = 0; i < NWORDS; i++) begin
            fold = fold ^ y_ext[i*SIG_W +: SIG_W];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // A zero-length run still reports completion via DONE.
                    state_next = (cycles == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_inc == cycles_lat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done are registered from the next state so they line up exactly
    // with the cycles spent in RUN and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= '0;
            sample_cnt <= '0;
            cycles_lat <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        signature  <= SEED;
                        sample_cnt <= '0;
                        cycles_lat <= cycles;
                    end
                end
                RUN: begin
                    signature  <= misr_step(signature, fold);
                    sample_cnt <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_signature_misr.sv
// ---------------------------------------------------------------------------
// tb_y_signature_misr
//
// Directed sequence of runs (fixed and random y) against a reference model
// that folds y bit by bit and advances the signature arithmetically.
// ---------------------------------------------------------------------------
module tb_y_signature_misr;

    localparam int          Y_W   = 246;
    localparam int          SIG_W = 32;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [15:0]      cycles;
    logic [Y_W-1:0]   y;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [15:0]      sample_cnt;

    int vectors    = 0;
    int miscompares = 0;

    y_signature_misr #(
        .Y_W  (Y_W),
        .SIG_W(SIG_W),
        .POLY (POLY),
        .SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cycles    (cycles),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference fold: bit j of y lands on signature bit j mod SIG_W.
    function automatic logic [31:0] fold_ref(input logic [Y_W-1:0] v);
        logic [31:0] f;
        f = '0;
        for (int j = 0; j < Y_W; j++) f[j % 32] = f[j % 32] ^ v[j];
        return f;
    endfunction

    // Reference step: multiply by x modulo 2^32, reduce by POLY on overflow.
    function automatic logic [31:0] step_ref(input logic [31:0] s, input logic [Y_W-1:0] v);
        longint t;
        t = longint'(s) * 2;
        if (t >= 64'h1_0000_0000) t = (t - 64'h1_0000_0000) ^ longint'(POLY);
        return t[31:0] ^ fold_ref(v);
    endfunction

    function automatic logic [Y_W-1:0] rand_y();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r[Y_W-1:0];
    endfunction

    // Full run: accept, absorb n samples, DONE, back to IDLE.
    task automatic do_run(input string nm, input int n, input bit rnd,
                          input logic [Y_W-1:0] fixed, input bit hold_start,
                          output logic [31:0] final_sig);
        logic [31:0]    m;
        logic [Y_W-1:0] v;
        start  = 1'b1;
        cycles = 16'(n);
        tick();
        m = SEED;
        chk({nm, "_acc_sig"}, signature, m);
        chk({nm, "_acc_cnt"}, 32'(sample_cnt), 0);
        chk({nm, "_acc_busy"}, 32'(busy), 32'(n != 0));
        chk({nm, "_acc_done"}, 32'(done), 32'(n == 0));
        if (!hold_start) start = 1'b0;
        cycles = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            v = rnd ? rand_y() : fixed;
            y = v;
            m = step_ref(m, v);
            tick();
            chk({nm, "_sig"}, signature, m);
            chk({nm, "_cnt"}, 32'(sample_cnt), 32'(i + 1));
            chk({nm, "_busy"}, 32'(busy), 32'(i + 1 < n));
            chk({nm, "_done"}, 32'(done), 32'(i + 1 == n));
        end
        y = rand_y();
        tick();
        chk({nm, "_end_done"}, 32'(done), 0);
        chk({nm, "_end_busy"}, 32'(busy), 0);
        chk({nm, "_end_sig"}, signature, m);
        chk({nm, "_end_cnt"}, 32'(sample_cnt), 32'(n));
        if (!hold_start) begin
            y = rand_y();
            tick();
            chk({nm, "_idle_sig"}, signature, m);
            chk({nm, "_idle_busy"}, 32'(busy), 0);
        end
        final_sig = m;
    endtask

    initial begin
        logic [31:0]    s;
        logic [31:0]    m;
        logic [Y_W-1:0] v;

        rst_n  = 1'b1;
        start  = 1'b0;
        cycles = '0;
        y      = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig", signature, 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // First edge with rst_n high accepts the run.
        do_run("one_zero", 1, 1'b0, '0, 1'b0, s);
        chk("one_zero_const", signature, 32'hFB3EE249);

        v = '0; v[0] = 1'b1;
        do_run("fold_b0", 1, 1'b0, v, 1'b0, s);
        chk("fold_b0_const", signature, 32'hFB3EE248);

        v = '0; v[32] = 1'b1;
        do_run("fold_b32", 1, 1'b0, v, 1'b0, s);
        chk("fold_b32_const", signature, 32'hFB3EE248);

        do_run("two_zero", 2, 1'b0, '0, 1'b0, s);
        chk("two_zero_const", signature, 32'hF2BCD925);

        do_run("len0", 0, 1'b0, '0, 1'b0, s);
        chk("len0_const", signature, 32'hFFFFFFFF);

        // start held high: second run only accepted from IDLE after DONE.
        do_run("hold_a", 3, 1'b1, '0, 1'b1, s);
        do_run("hold_b", 3, 1'b1, '0, 1'b0, s);

        do_run("rnd5", 5, 1'b1, '0, 1'b0, s);
        do_run("rnd17", 17, 1'b1, '0, 1'b0, s);

        // Reset mid-run after 40 of 100 samples.
        start  = 1'b1;
        cycles = 16'd100;
        tick();
        start = 1'b0;
        m = SEED;
        for (int i = 0; i < 40; i++) begin
            v = rand_y();
            y = v;
            m = step_ref(m, v);
            tick();
        end
        chk("mid_sig", signature, m);
        chk("mid_cnt", 32'(sample_cnt), 40);
        chk("mid_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sig", signature, 0);
        chk("arst_cnt", 32'(sample_cnt), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            y = rand_y();
            tick();
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        do_run("after_rst", 6, 1'b1, '0, 1'b0, s);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/y_signature_misr.md
Y_SIGNATURE_MISR -- requirements
Module: y_signature_misr

Interface
REQ-001 SHALL have parameter Y_W, default 246, width of the consumed DUT output bus y.
REQ-002 SHALL have parameter SIG_W, default 32, signature width.
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, MISR feedback polynomial.
REQ-004 SHALL have parameter SEED, default 32'hFFFFFFFF, signature value loaded at run start.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  run request, sampled on clk.
REQ-008 SHALL have port cycles  input  16  number of y samples in the run, latched on accepted start.
REQ-009 SHALL have port y  input  Y_W  output bus of the DUT under equivalence test.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  single-cycle pulse at run end.
REQ-012 SHALL have port signature  output  SIG_W  current/final MISR value.
REQ-013 SHALL have port sample_cnt  output  16  samples absorbed in the current or last run.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; registered outputs only.
REQ-015 SHALL fold y each cycle: zero-extend to the next multiple of SIG_W (256 for defaults), split into SIG_W-bit words, XOR all words -> fold.
REQ-016 SHALL update in RUN: signature <= {signature[SIG_W-2:0],0} ^ (signature[SIG_W-1] ? POLY : 0) ^ fold.
REQ-017 SHALL, in IDLE with start=1 and cycles!=0: at that edge load signature=SEED, sample_cnt=0, latch cycles, enter RUN.
REQ-018 SHALL, in IDLE with start=1 and cycles==0: load signature=SEED, sample_cnt=0, enter DONE directly (no samples).
REQ-019 SHALL, in RUN, absorb y on every edge (no stall) and increment sample_cnt by 1.
REQ-020 SHALL leave RUN for DONE on the edge absorbing the sample that makes sample_cnt equal latched cycles; busy falls on that edge.
REQ-021 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-022 SHALL ignore start while in RUN or DONE; latched cycles unaffected by input changes after acceptance.
REQ-023 SHALL hold signature and sample_cnt stable in IDLE and DONE until the next accepted start.
REQ-024 SHALL give latency: accepted start at edge E0 -> samples at E1..EN -> done high during cycle after EN, N=cycles.
REQ-025 SHALL use modulo-2^SIG_W arithmetic; sample_cnt never wraps (max 65535 = max cycles).

Reset
REQ-026 SHALL on rst_n low, immediately and regardless of clk: state=IDLE, busy=0, done=0, signature=0, sample_cnt=0, latched cycles=0.
REQ-027 SHALL abort any run in progress on reset; no done pulse for the aborted run.
REQ-028 SHALL accept start on the first rising edge with rst_n high.

Verification
REQ-029 SHALL verify reset: rst_n low mid-RUN (cycles=100, after 40 samples) -> busy=0, done=0, signature=0, sample_cnt=0 without a clk edge; subsequent start runs normally.
REQ-030 SHALL verify single sample: start, cycles=1, y=0 -> done one cycle after the sample edge, signature=32'hFB3EE249, sample_cnt=1.
REQ-031 SHALL verify fold: start, cycles=1, y=246'h1 -> signature=32'hFB3EE248; y with bit 32 set only -> same value.
REQ-032 SHALL verify two samples: cycles=2, y=0 both cycles -> signature=32'hF2BCD925, busy high exactly 2 cycles.
REQ-033 SHALL verify cycles=0: start -> busy never high, done high the following cycle, signature=32'hFFFFFFFF, sample_cnt=0.
REQ-034 SHALL verify start ignored: start held high throughout a cycles=3 run -> one done pulse, sample_cnt=3, new run accepted only from IDLE after DONE.
